// File: rtl/enc_pkg.sv
// Shared definitions for the encoder event path: code type, drop counter width
// and the saturating increment used by the optional drop counter.
package enc_pkg;

    localparam int ENC_CODE_W = 2;
    typedef logic [ENC_CODE_W-1:0] code_t;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        logic [DROP_CNT_W-1:0] result;
        result = value;
        if (value != DROP_CNT_MAX) begin
            result = value + DROP_CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/enc_change_detect.sv
// Change detector for the encoder output: pulses evt when a valid code appears
// or the valid code differs from the one seen on the previous cycle.
module enc_change_detect
    import enc_pkg::*;
#(
    parameter int CODE_W = ENC_CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              evt
);

    logic              prev_valid_q;
    logic              prev_valid_d;
    logic [CODE_W-1:0] prev_code_q;
    logic [CODE_W-1:0] prev_code_d;

    // History follows the input every cycle, even when the FIFO drops the event.
    always_comb begin
        prev_valid_d = in_valid;
        prev_code_d  = in_code;
        evt          = in_valid && (!prev_valid_q || (in_code != prev_code_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid_q <= 1'b0;
            prev_code_q  <= '0;
        end else begin
            prev_valid_q <= prev_valid_d;
            prev_code_q  <= prev_code_d;
        end
    end

endmodule

// File: rtl/enc_event_fifo.sv
// Event capture queue: detected encoder events are buffered in a FWFT FIFO.
// Defining ENC_FIFO_DROP_CNT_EN adds a saturating drop_cnt output.
module enc_event_fifo
    import enc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int CODE_W = ENC_CODE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [CODE_W-1:0]      in_code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CODE_W-1:0]      out_code,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
`ifdef ENC_FIFO_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]  drop_cnt,
`endif
    input  logic                   ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              evt;
    logic              push;
    logic              pop;
    logic              drop;

    logic [CODE_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overflow_q;
    logic              overflow_d;

    enc_change_detect #(
        .CODE_W (CODE_W)
    ) u_change_detect (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_code  (in_code),
        .evt      (evt)
    );

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign out_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    // Gate the unreset memory so out_code reads 0 whenever nothing is stored.
    assign out_code  = out_valid ? mem[rd_ptr_q] : '0;

    always_comb begin
        pop  = out_valid && out_ready;
        push = evt && (!full || pop);
        drop = evt && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        overflow_d = ovf_clr ? 1'b0 : (overflow_q || drop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_code;
        end
    end

`ifdef ENC_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (ovf_clr) begin
            drop_cnt_d = '0;
        end else if (drop) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_enc_event_fifo.sv
// Bench for enc_event_fifo: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_enc_event_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_code;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;
`ifdef ENC_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int total;
    int bad;

    logic [1:0] m_q[$];
    bit         m_prev_valid;
    logic [1:0] m_prev_code;
    bit         m_ovf;
    int         m_drop;

    enc_event_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
`ifdef ENC_FIFO_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_prev_valid = 1'b0;
        m_prev_code  = 2'b00;
        m_ovf        = 1'b0;
        m_drop       = 0;
    endtask

    task automatic model_edge();
        bit ev;
        bit is_full;
        bit do_pop;
        bit do_drop;
        ev      = in_valid && (!m_prev_valid || in_code != m_prev_code);
        is_full = (m_q.size() == DEPTH);
        do_pop  = (m_q.size() != 0) && out_ready;
        do_drop = ev && is_full && !do_pop;
        if (do_pop) void'(m_q.pop_front());
        if (ev && (!is_full || do_pop)) m_q.push_back(in_code);
        if (ovf_clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end else if (do_drop) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
        m_prev_valid = in_valid;
        m_prev_code  = in_code;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = 2'b00;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        repeat (5) tick();
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %0b expected 1", empty); end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
        total++; if (out_code !== 2'b00) begin bad++; $display("[TB] FAIL reset_out_code: got %0d expected 0", out_code); end
    endtask

    task automatic test_hold_one();
        in_valid  = 1'b1;
        in_code   = 2'b10;
        out_ready = 1'b0;
        repeat (4) tick();
        total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL hold_count: got %0d expected 1", count); end
        total++; if (out_code !== 2'b10) begin bad++; $display("[TB] FAIL hold_code: got %0d expected 2", out_code); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL hold_valid: got %0b expected 1", out_valid); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL hold_drain_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_order();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_code !== 2'(i)) begin bad++; $display("[TB] FAIL order_code[%0d]: got %0d expected %0d", i, out_code, i); end
            tick();
        end
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL order_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i % 4);
            tick();
        end
        total++; if (full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_full: got %0b expected 1", full); end
        total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL ovf_count: got %0d expected 8", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
`ifdef ENC_FIFO_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("[TB] FAIL ovf_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_code !== 2'(i % 4)) begin bad++; $display("[TB] FAIL ovf_drain[%0d]: got %0d expected %0d", i, out_code, i % 4); end
            tick();
        end
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL ovf_drain_empty: got %0b expected 1", empty); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow); end
        out_ready = 1'b0;
        ovf_clr   = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clear: got %0b expected 0", overflow); end
`ifdef ENC_FIFO_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL ovf_drop_clear: got %0d expected 0", drop_cnt); end
`endif
    endtask

    task automatic test_full_pop();
        logic [1:0] exp_seq [8];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i % 4);
            tick();
        end
        in_code   = 2'd1;
        out_ready = 1'b1;
        tick();
        total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL fullpop_count: got %0d expected 8", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL fullpop_overflow: got %0b expected 0", overflow); end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (out_code !== exp_seq[i]) begin bad++; $display("[TB] FAIL fullpop_drain[%0d]: got %0d expected %0d", i, out_code, exp_seq[i]); end
            tick();
        end
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL fullpop_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_code  = 2'(i % 4);
            tick();
        end
        total++; if (count !== 4'd5) begin bad++; $display("[TB] FAIL rstmid_pre_count: got %0d expected 5", count); end
        in_code = 2'd2;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL rstmid_count: got %0d expected 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid: got %0b expected 0", out_valid); end
        #2;
        rst_n = 1'b1;
        repeat (3) tick();
        total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL rstmid_post_count: got %0d expected 1", count); end
        total++; if (out_code !== 2'd2) begin bad++; $display("[TB] FAIL rstmid_post_code: got %0d expected 2", out_code); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_drain: got %0b expected 1", empty); end
    endtask

    task automatic test_random();
        logic [3:0] exp_cnt;
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) in_code = 2'($urandom_range(0, 3));
            if (c < 300) out_ready = ($urandom_range(0, 3) == 0);
            else         out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr = ($urandom_range(0, 40) == 0);
            tick();
            exp_cnt = 4'(m_q.size());
            total++; if (count !== exp_cnt) begin bad++; $display("[TB] FAIL rand_count@%0d: got %0d expected %0d", c, count, exp_cnt); end
            total++; if (out_valid !== (m_q.size() != 0)) begin bad++; $display("[TB] FAIL rand_valid@%0d: got %0b expected %0b", c, out_valid, m_q.size() != 0); end
            total++; if (full !== (m_q.size() == DEPTH)) begin bad++; $display("[TB] FAIL rand_full@%0d: got %0b expected %0b", c, full, m_q.size() == DEPTH); end
            total++; if (overflow !== m_ovf) begin bad++; $display("[TB] FAIL rand_overflow@%0d: got %0b expected %0b", c, overflow, m_ovf); end
            if (m_q.size() != 0) begin
                total++; if (out_code !== m_q[0]) begin bad++; $display("[TB] FAIL rand_code@%0d: got %0d expected %0d", c, out_code, m_q[0]); end
            end
`ifdef ENC_FIFO_DROP_CNT_EN
            total++; if (drop_cnt !== 8'(m_drop)) begin bad++; $display("[TB] FAIL rand_drop_cnt@%0d: got %0d expected %0d", c, drop_cnt, m_drop); end
`endif
        end
        ovf_clr = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_hold_one();
        test_order();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
